// File: rtl/ffs_pkg.sv
// Shared definitions for the find-first-set family of blocks.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ffs_pkg;

  // Widest candidate vector that msb_onehot can produce.
  localparam int MAX_CANDIDATES = 1024;

  // Index width for a candidate vector of n entries.
  function automatic int ffs_iw(input int n);
    return $clog2(n);
  endfunction

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } ffs_state_e;

  // MSB-first one-hot: index 0 maps to bit n-1. Callers keep the low n bits.
  function automatic logic [MAX_CANDIDATES-1:0] msb_onehot(input int index, input int n);
    return {{(MAX_CANDIDATES-1){1'b0}}, 1'b1} << (n - 1 - index);
  endfunction

endpackage

// File: rtl/ffs_decode.sv
// MSB-first index to one-hot decoder (index 0 -> bit N_CANDIDATES-1).
// Latency: combinational.
// Backpressure: none; pure function of index_i.
// Ports: index_i [IW-1:0] slot index; onehot_o [N_CANDIDATES-1:0] decoded bit.
module ffs_decode
  import ffs_pkg::*;
#(
  parameter  int N_CANDIDATES = 8,
  localparam int IW           = ffs_iw(N_CANDIDATES)
) (
  input  logic [IW-1:0]           index_i,
  output logic [N_CANDIDATES-1:0] onehot_o
);

  if (N_CANDIDATES < 2 || N_CANDIDATES > MAX_CANDIDATES ||
      (N_CANDIDATES & (N_CANDIDATES - 1)) != 0) begin : g_bad_n
    $fatal(1, "ffs_decode: N_CANDIDATES must be a power of 2 in [2, MAX_CANDIDATES]");
  end

  assign onehot_o = N_CANDIDATES'(msb_onehot(32'(index_i), N_CANDIDATES));

endmodule

// File: rtl/ffs_mask_builder.sv
// Accumulates a packet of MSB-first slot indices into a bitmap with popcount and duplicate flag.
// Latency: o_valid rises the cycle after the i_last beat is accepted; one HOLD bubble per packet.
// Backpressure: o_ready low while a result is held; held until i_ready, o_ready returns next cycle.
// Ports: clk/rst (sync active-high); i_valid/i_index/i_last/o_ready upstream beat handshake;
//        o_valid/o_mask/o_count/o_dup/i_ready downstream result handshake.
module ffs_mask_builder
  import ffs_pkg::*;
#(
  parameter  int N_CANDIDATES = 8,
  localparam int IW           = ffs_iw(N_CANDIDATES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [IW-1:0]           i_index,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [N_CANDIDATES-1:0] o_mask,
  output logic [IW:0]             o_count,
  output logic                    o_dup,
  input  logic                    i_ready
);

  if (N_CANDIDATES < 2 || (N_CANDIDATES & (N_CANDIDATES - 1)) != 0) begin : g_bad_n
    $fatal(1, "ffs_mask_builder: N_CANDIDATES must be a power of 2 >= 2");
  end

  localparam logic [IW:0] CNT_ONE = 1;

  ffs_state_e              state_q, state_d;
  logic [N_CANDIDATES-1:0] acc_q, acc_d;
  logic [IW:0]             cnt_q, cnt_d;
  logic                    dup_q, dup_d;

  logic [N_CANDIDATES-1:0] beat_onehot;
  logic                    beat_hit;

  ffs_decode #(.N_CANDIDATES(N_CANDIDATES)) u_decode (
    .index_i  (i_index),
    .onehot_o (beat_onehot)
  );

  // A repeated index leaves the mask and count unchanged, so count cannot exceed N_CANDIDATES.
  assign beat_hit = |(acc_q & beat_onehot);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dup_d   = dup_q;
    unique case (state_q)
      ACCUM: begin
        if (i_valid) begin
          acc_d = acc_q | beat_onehot;
          if (beat_hit) begin
            dup_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (i_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // i_valid is ignored here; a beat offered on the release cycle is left for ACCUM.
        if (i_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          dup_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
    end
  end

  // Handshake outputs depend on state only.
  assign o_ready = (state_q == ACCUM);
  assign o_valid = (state_q == HOLD);
  assign o_mask  = acc_q;
  assign o_count = cnt_q;
  assign o_dup   = dup_q;

endmodule

// File: tb/tb_ffs_mask_builder.sv
// Self-checking bench for ffs_mask_builder: directed scenarios plus randomized packets
// against a set/count reference model. N=8 instance for most tests, N=16 for the full mask.
module tb_ffs_mask_builder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N = 8 instance
  logic       v8 = 1'b0, last8 = 1'b0, ir8 = 1'b0;
  logic [2:0] idx8 = '0;
  logic       o_ready8, o_valid8, o_dup8;
  logic [7:0] o_mask8;
  logic [3:0] o_count8;

  // N = 16 instance
  logic        v16 = 1'b0, last16 = 1'b0, ir16 = 1'b0;
  logic [3:0]  idx16 = '0;
  logic        o_ready16, o_valid16, o_dup16;
  logic [15:0] o_mask16;
  logic [4:0]  o_count16;

  ffs_mask_builder #(.N_CANDIDATES(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (v8),
    .i_index (idx8),
    .i_last  (last8),
    .o_ready (o_ready8),
    .o_valid (o_valid8),
    .o_mask  (o_mask8),
    .o_count (o_count8),
    .o_dup   (o_dup8),
    .i_ready (ir8)
  );

  ffs_mask_builder #(.N_CANDIDATES(16)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (v16),
    .i_index (idx16),
    .i_last  (last16),
    .o_ready (o_ready16),
    .o_valid (o_valid16),
    .o_mask  (o_mask16),
    .o_count (o_count16),
    .o_dup   (o_dup16),
    .i_ready (ir16)
  );

  // Observation vectors: {valid, ready, mask, count, dup}
  logic [14:0] obs8;
  logic [23:0] obs16;
  assign obs8  = {o_valid8, o_ready8, o_mask8, o_count8, o_dup8};
  assign obs16 = {o_valid16, o_ready16, o_mask16, o_count16, o_dup16};

  int n_checks = 0;
  int n_fail   = 0;

  // All stimulus changes and all sampling happen on the falling edge.
  task automatic beat8(input int idx, input bit last);
    v8    = 1'b1;
    idx8  = 3'(idx);
    last8 = last;
    @(negedge clk);
    v8    = 1'b0;
    last8 = 1'b0;
  endtask

  task automatic release8();
    ir8 = 1'b1;
    @(negedge clk);
    ir8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (obs8 !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0}) begin
      $display("FAIL reset8: got %h expected %h", obs8, {1'b0, 1'b1, 8'h00, 4'd0, 1'b0});
      n_fail++;
    end
    n_checks++;
    if (obs16 !== {1'b0, 1'b1, 16'h0000, 5'd0, 1'b0}) begin
      $display("FAIL reset16: got %h expected %h", obs16, {1'b0, 1'b1, 16'h0000, 5'd0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_single();
    beat8(0, 1'b1);
    n_checks++;
    if (obs8 !== {1'b1, 1'b0, 8'b1000_0000, 4'd1, 1'b0}) begin
      $display("FAIL single_hold: got %h expected %h", obs8, {1'b1, 1'b0, 8'b1000_0000, 4'd1, 1'b0});
      n_fail++;
    end
    release8();
    n_checks++;
    if (obs8 !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0}) begin
      $display("FAIL single_release: got %h expected %h", obs8, {1'b0, 1'b1, 8'h00, 4'd0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_multi_stall();
    logic [14:0] exp;
    exp = {1'b1, 1'b0, 8'b0010_0101, 4'd3, 1'b0};
    beat8(2, 1'b0);
    beat8(5, 1'b0);
    beat8(7, 1'b1);
    // Offer beats while held; they must not be consumed.
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (obs8 !== exp) begin
        $display("FAIL multi_stall_c%0d: got %h expected %h", c, obs8, exp);
        n_fail++;
      end
      v8 = 1'b1; idx8 = 3'(c); last8 = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (obs8 !== exp) begin
      $display("FAIL multi_stall_end: got %h expected %h", obs8, exp);
      n_fail++;
    end
    // Beat still offered on the release cycle: must be ignored.
    ir8 = 1'b1;
    @(negedge clk);
    ir8 = 1'b0; v8 = 1'b0; last8 = 1'b0;
    n_checks++;
    if (obs8 !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0}) begin
      $display("FAIL release_beat_ignored: got %h expected %h", obs8, {1'b0, 1'b1, 8'h00, 4'd0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_dup();
    beat8(3, 1'b0);
    beat8(3, 1'b0);
    beat8(6, 1'b1);
    n_checks++;
    if (obs8 !== {1'b1, 1'b0, 8'b0001_0010, 4'd2, 1'b1}) begin
      $display("FAIL dup_pkt: got %h expected %h", obs8, {1'b1, 1'b0, 8'b0001_0010, 4'd2, 1'b1});
      n_fail++;
    end
    release8();
    beat8(1, 1'b1);
    n_checks++;
    if (obs8 !== {1'b1, 1'b0, 8'b0100_0000, 4'd1, 1'b0}) begin
      $display("FAIL dup_cleared: got %h expected %h", obs8, {1'b1, 1'b0, 8'b0100_0000, 4'd1, 1'b0});
      n_fail++;
    end
    release8();
  endtask

  task automatic test_back_to_back_full16();
    int accepts = 0;
    for (int i = 0; i < 16; i++) begin
      v16 = 1'b1; idx16 = 4'(i); last16 = (i == 15);
      if (o_ready16 === 1'b1) accepts++;
      @(negedge clk);
    end
    v16 = 1'b0; last16 = 1'b0;
    n_checks++;
    if (accepts != 16) begin
      $display("FAIL full16_accepts: got %0d expected 16", accepts);
      n_fail++;
    end
    n_checks++;
    if (obs16 !== {1'b1, 1'b0, 16'hFFFF, 5'd16, 1'b0}) begin
      $display("FAIL full16_mask: got %h expected %h", obs16, {1'b1, 1'b0, 16'hFFFF, 5'd16, 1'b0});
      n_fail++;
    end
    ir16 = 1'b1;
    @(negedge clk);
    ir16 = 1'b0;
    n_checks++;
    if (obs16 !== {1'b0, 1'b1, 16'h0000, 5'd0, 1'b0}) begin
      $display("FAIL full16_release: got %h expected %h", obs16, {1'b0, 1'b1, 16'h0000, 5'd0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_packet();
    beat8(4, 1'b0);
    beat8(1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (obs8 !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0}) begin
      $display("FAIL reset_mid_empty: got %h expected %h", obs8, {1'b0, 1'b1, 8'h00, 4'd0, 1'b0});
      n_fail++;
    end
    beat8(6, 1'b1);
    n_checks++;
    if (obs8 !== {1'b1, 1'b0, 8'b0000_0010, 4'd1, 1'b0}) begin
      $display("FAIL reset_mid_pkt: got %h expected %h", obs8, {1'b1, 1'b0, 8'b0000_0010, 4'd1, 1'b0});
      n_fail++;
    end
    // Reset while holding discards the result.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (obs8 !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0}) begin
      $display("FAIL reset_in_hold: got %h expected %h", obs8, {1'b0, 1'b1, 8'h00, 4'd0, 1'b0});
      n_fail++;
    end
  endtask

  // Reference model: the packet is a set of slots; mask has slot s at bit 7-s,
  // count is the set size, dup means some index arrived more than once.
  task automatic test_random_packets();
    for (int p = 0; p < 40; p++) begin
      int   n_beats;
      int   idx;
      int   count;
      bit   dup;
      bit   seen [8];
      logic [7:0]  mask;
      logic [14:0] exp;
      n_beats = $urandom_range(1, 10);
      count = 0; dup = 1'b0; mask = '0;
      for (int s = 0; s < 8; s++) seen[s] = 1'b0;
      for (int b = 0; b < n_beats; b++) begin
        while ($urandom_range(0, 3) == 0) begin
          v8 = 1'b0; idx8 = 3'($urandom_range(0, 7)); last8 = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        last8 = 1'b0;
        idx = $urandom_range(0, 7);
        if (seen[idx]) dup = 1'b1;
        else begin
          seen[idx] = 1'b1;
          count = count + 1;
        end
        mask = mask | 8'(1 << (7 - idx));
        beat8(idx, b == n_beats - 1);
      end
      exp = {1'b1, 1'b0, mask, 4'(count), dup};
      for (int st = 0; st <= int'($urandom_range(0, 3)); st++) begin
        n_checks++;
        if (obs8 !== exp) begin
          $display("FAIL rand_pkt%0d_cyc%0d: got %h expected %h", p, st, obs8, exp);
          n_fail++;
        end
        v8 = 1'b1; idx8 = 3'($urandom_range(0, 7));
        @(negedge clk);
        v8 = 1'b0;
      end
      // Held result survives any stall; one more look, then release.
      n_checks++;
      if (obs8 !== exp) begin
        $display("FAIL rand_pkt%0d_final: got %h expected %h", p, obs8, exp);
        n_fail++;
      end
      release8();
      n_checks++;
      if (o_ready8 !== 1'b1 || o_valid8 !== 1'b0) begin
        $display("FAIL rand_pkt%0d_release: got rdy=%b vld=%b expected rdy=1 vld=0", p, o_ready8, o_valid8);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_stall();
    test_dup();
    test_back_to_back_full16();
    test_reset_mid_packet();
    test_random_packets();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ffs_mask_builder.md
# ffs_mask_builder

Sequential index-to-bitmap builder, the decode-side counterpart of the team's find-first-set encoders. It accepts a stream of slot indices over a valid/ready handshake. Each index is decoded MSB-first: index 0 sets bit N_CANDIDATES-1. The one-hot bits of one packet are ORed into a mask, and the mask is presented downstream with a population count and a duplicate flag. Applying any FFS encoder to a single-index mask from this block returns that index.

## Interface
- N_CANDIDATES, 8, mask width; power of 2, ≥ 2; index width IW = $clog2(N_CANDIDATES)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- i_valid  input  1  upstream index beat valid
- i_index  input  IW  slot index; MSB-first numbering
- i_last  input  1  beat closes the current packet
- o_ready  output  1  builder can accept a beat
- o_valid  output  1  mask result valid
- o_mask  output  N_CANDIDATES  accumulated mask
- o_count  output  IW+1  number of set bits in o_mask
- o_dup  output  1  at least one index in the packet repeated
- i_ready  input  1  downstream accepts the result

## Operation
- States: ACCUM, HOLD. Reset state: ACCUM.
- Reset values: all outputs 0 except o_ready = 1; accumulator = 0; count = 0; dup = 0.
- ACCUM behaviour:
  - o_ready = 1; o_valid = 0.
  - A beat is accepted when i_valid && o_ready.
  - For an accepted beat, bit (N_CANDIDATES-1-i_index) of the accumulator is set.
  - If that bit was already set, dup is set sticky for the packet, and count does not increment.
  - Otherwise count increments by 1.
  - Count never exceeds N_CANDIDATES, so it fits IW+1 bits; no wrap.
- Last beat: an accepted beat with i_last = 1 includes its own bit in the result, then the state moves to HOLD.
- Single-beat packets (i_last on the first beat) are legal. There is no empty packet.
- HOLD behaviour:
  - o_valid = 1; o_ready = 0.
  - o_mask, o_count and o_dup are stable, and i_valid is ignored.
  - When i_ready = 1: clear the accumulator, count and dup, then return to ACCUM.
- Simultaneous events: rst overrides everything. A beat presented in the cycle HOLD is released is not accepted, because o_ready = 0 in that cycle.
- Reset mid-packet or in HOLD: the partial or held result is discarded, with no output beat. The next cycle is ACCUM with empty state.
- Out-of-range indices cannot occur, since N_CANDIDATES is a power of 2.

## Timing
- Latency: o_valid rises the cycle after the i_last beat is accepted.
- Downstream handshake: the result is presented for ≥1 cycle and completes when o_valid && i_ready. o_ready rises the next cycle.
- Throughput: one index per cycle within a packet. Between packets there is one mandatory bubble: the HOLD cycle, plus any i_ready stall.
- o_count and o_dup are registered and valid with o_mask. No combinational path from i_valid to o_valid.
- o_ready is a function of state only; no combinational path from i_ready.

## Structure
- Shared package ffs_pkg:
  - localparam function for IW;
  - state enum typedef {ACCUM, HOLD};
  - function msb_onehot(index) returning the MSB-first one-hot vector, reused by future FFS-family blocks.
- Sub-module ffs_decode (combinational): N_CANDIDATES parameter, index in, one-hot out, MSB-first. It is instantiated once here.
- Assertion on N_CANDIDATES being a power of 2 ≥ 2, fatal at elaboration.

## Test plan
- Reset check: drive rst 2 cycles, then release → o_ready=1, o_valid=0, o_mask=0, o_count=0, o_dup=0.
- Single-beat packet, N=8: index 0 with last → next cycle o_mask=8'b1000_0000, o_count=1, o_dup=0. With i_ready=1 → o_ready=1 the following cycle.
- Multi-beat packet, N=8: indices 2, 5, 7 (last on 7) → o_mask=8'b0010_0101, o_count=3. Hold i_ready=0 for 4 cycles → outputs stable, o_ready=0, beats offered meanwhile not consumed.
- Duplicate: indices 3, 3, 6(last) → o_mask=8'b0001_0010, o_count=2, o_dup=1. The next packet, index 1 alone → o_dup=0, o_mask=8'b0100_0000.
- Full mask, N=16: indices 0..15 back-to-back, i_valid held high, last on 15 → o_mask=16'hFFFF, o_count=16. No beat dropped; 16 consecutive accepts.
- Reset mid-packet: indices 4, 1, then rst for 1 cycle, then index 6 with last → o_mask=8'b0000_0010, o_count=1 (pre-reset bits discarded).
